fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Owns the program counter (PC) and instruction register (IR) and drives the instruction-memory port. Sits directly downstream of the controller FSM.
- Consumes the controller's PC_clr/PC_inc/PC_ld/I_rd/IR_ld strobes and returns the 16-bit instruction word the controller decodes.
- Supports variable-latency instruction memory through a req/ack handshake. Stalls the controller via fetch_busy and flags memory timeouts.

Parameters:
- PC_W, 8, PC and instruction-address width.
- INSTR_W, 16, instruction width.
- TIMEOUT, 15, max imem_req cycles without imem_ack before abort (must be >= 1).
- ERR_INSTR, 16'hF000, word loaded into IR on timeout (undefined opcode, so the controller takes its error path).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC_clr  in  1  clear PC to 0.
- PC_inc  in  1  increment PC when the current fetch completes.
- PC_ld  in  1  load jump target into PC.
- I_rd  in  1  start an instruction fetch.
- IR_ld  in  1  load fetched word into IR.
- imem_addr  out  PC_W  fetch address, stable while imem_req=1.
- imem_req  out  1  memory read request.
- imem_ack  in  1  read data valid; sampled only while imem_req=1.
- imem_rdata  in  INSTR_W  read data.
- instruction  out  INSTR_W  IR contents.
- pc  out  PC_W  current PC.
- fetch_busy  out  1  controller must hold its FETCH state while high.
- fetch_err  out  1  sticky timeout flag; cleared only by reset or PC_clr.

Behaviour:
- Reset (rst=0, asynchronous): PC=0, IR=0, state IDLE, imem_req=0, imem_addr=0, wait counter=0, fetch_err=0, fetch_busy=0.
- States:
  - IDLE: start a fetch when I_rd=1. Latch imem_addr<=PC and latch the sampled PC_inc/IR_ld, then go to WAIT.
  - WAIT: imem_req=1 (registered). Wait counter increments each cycle without ack.
  - Ack received: if latched IR_ld, IR<=imem_rdata. If latched PC_inc, PC<=PC+1 mod 2^PC_W. Counter cleared, go to IDLE.
  - Counter reaches TIMEOUT without ack: IR<=ERR_INSTR, fetch_err<=1, PC unchanged, drop req, go to IDLE.
- fetch_busy = (state==WAIT) | (state==IDLE & I_rd), combinational. The controller advances only after a cycle with fetch_busy=0.
- Latency: I_rd at cycle t, imem_req first high at t+1; ack at t+1+k updates IR/PC at the edge ending that cycle.
  - Minimum I_rd to new instruction visible: 2 cycles (k=0).
- Handshake: imem_req stays high until the ack cycle or the timeout cycle, then drops for at least 1 cycle. imem_addr does not change while req=1. Ack while req=0 is ignored.
- PC_ld (IDLE only): PC <= PC + sext(IR[7:0]) - 1, mod 2^PC_W. The -1 compensates for the increment during fetch.
- Priority:
  - PC_clr overrides everything in any state. PC=0, fetch_err=0, abort any fetch: req drops next cycle, IR unchanged, state IDLE, and a same-cycle ack is discarded.
  - PC_ld is ignored in WAIT.
  - PC_ld together with I_rd in IDLE: load PC first; the fetch uses the old PC.
- PC_inc or IR_ld without I_rd: no effect.
- Wrap: PC 0xFF + 1 gives 0x00. Jump targets wrap modulo 256.
- Reset asserted mid-fetch: immediate return to reset values, req low asynchronously.

Decomposition:
- Shared package cpu_pkg:
  - PC_W, INSTR_W, ERR_INSTR constants.
  - t_fetch_state enum {IDLE, WAIT}.
  - sext8 function.
- One natural sub-module: pc_reg (PC register with clr/ld/inc and priority).
- The FSM, IR and handshake stay in fetch_unit.

Test Plan:
- Reset release; pulse I_rd with PC_inc/IR_ld=1; memory acks at first req cycle with 16'h3A05 -> imem_addr=0x00, instruction=16'h3A05 two cycles after I_rd, pc=0x01, fetch_busy high exactly 2 cycles.
- Memory inserts 3 wait cycles returning 16'h2123 at address 0x01 -> req high 4 cycles, addr held 0x01, IR=16'h2123, pc=0x02, no fetch_err.
- PC=0x10, IR=16'h50FD, PC_ld pulse -> pc=0x0C. Then PC=0x02, IR[7:0]=0x7F -> pc=0x80.
- Memory never acks, TIMEOUT=15 -> req drops after 15 cycles, instruction=16'hF000, fetch_err=1, pc unchanged. A later PC_clr clears fetch_err and pc=0.
- PC_clr asserted in 2nd WAIT cycle with ack in same cycle -> ack discarded, IR unchanged, pc=0, req low next cycle, state IDLE.
- PC preset 0xFF, fetch with PC_inc -> pc=0x00. Assert rst during WAIT -> imem_req low immediately, all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, fetch FSM state type and the branch-offset helper used by the
// fetch datapath.
package cpu_pkg;

  localparam int PC_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] ERR_INSTR = 16'hF000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t_fetch_state;

  function automatic logic [PC_W-1:0] sext8(input logic [7:0] b);
    return PC_W'(signed'(b));
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register; clear beats jump-load, which beats increment.
module pc_reg #(
  parameter int W = cpu_pkg::PC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] target,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (clr)
      pc <= '0;
    else if (ld)
      pc <= target;
    else if (inc)
      pc <= pc + W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC and IR, runs the req/ack handshake with a
// variable-latency instruction memory and aborts slow fetches with ERR_INSTR.
module fetch_unit #(
  parameter int                 PC_W      = cpu_pkg::PC_W,
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter int                 TIMEOUT   = 15,
  parameter logic [INSTR_W-1:0] ERR_INSTR = cpu_pkg::ERR_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_clr,
  input  logic               PC_inc,
  input  logic               PC_ld,
  input  logic               I_rd,
  input  logic               IR_ld,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  import cpu_pkg::t_fetch_state;
  import cpu_pkg::IDLE;
  import cpu_pkg::WAIT;
  import cpu_pkg::sext8;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  t_fetch_state           state;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   want_inc;
  logic                   want_ir;
  logic [INSTR_W-1:0]     ir;
  logic                   pc_ld_en;
  logic                   pc_inc_en;
  logic [PC_W-1:0]        jump_target;

  // The -1 undoes the increment that already happened while this jump was fetched.
  assign jump_target = pc + PC_W'(sext8(ir[7:0])) - PC_W'(1);
  assign pc_ld_en    = PC_ld && (state == IDLE);
  assign pc_inc_en   = (state == WAIT) && imem_ack && want_inc;
  assign fetch_busy  = (state == WAIT) || ((state == IDLE) && I_rd);
  assign instruction = ir;

  pc_reg #(.W(PC_W)) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (PC_clr),
    .ld     (pc_ld_en),
    .inc    (pc_inc_en),
    .target (jump_target),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      wait_cnt  <= '0;
      want_inc  <= 1'b0;
      want_ir   <= 1'b0;
      ir        <= '0;
      fetch_err <= 1'b0;
    end else if (PC_clr) begin
      // Abort: any ack arriving in this cycle is dropped along with the fetch.
      state     <= IDLE;
      imem_req  <= 1'b0;
      wait_cnt  <= '0;
      want_inc  <= 1'b0;
      want_ir   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_rd) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            want_inc  <= PC_inc;
            want_ir   <= IR_ld;
            wait_cnt  <= '0;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            if (want_ir)
              ir <= imem_rdata;
            state    <= IDLE;
            imem_req <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            ir        <= ERR_INSTR;
            fetch_err <= 1'b1;
            state     <= IDLE;
            imem_req  <= 1'b0;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-built corner
// sequences and a randomized run against a PC/IR/error reference model.
module tb_fetch_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PC_clr = 1'b0;
  logic        PC_inc = 1'b0;
  logic        PC_ld = 1'b0;
  logic        I_rd = 1'b0;
  logic        IR_ld = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic        fetch_busy;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_clr      (PC_clr),
    .PC_inc      (PC_inc),
    .PC_ld       (PC_ld),
    .I_rd        (I_rd),
    .IR_ld       (IR_ld),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err)
  );

  typedef enum int {OP_FETCH, OP_JUMP, OP_CLR} op_e;

  typedef struct {
    op_e         op;
    logic        inc;
    logic        irld;
    int          k;
    logic [15:0] data;
    logic [7:0]  expAddr;
    int          expReq;
    logic [7:0]  expPc;
    logic [15:0] expIr;
    logic        expErr;
  } vec_t;

  function automatic vec_t mk(op_e op, logic inc, logic irld, int k, logic [15:0] data,
                              logic [7:0] ea, int er, logic [7:0] ep, logic [15:0] ei,
                              logic ee);
    vec_t v;
    v.op = op; v.inc = inc; v.irld = irld; v.k = k; v.data = data;
    v.expAddr = ea; v.expReq = er; v.expPc = ep; v.expIr = ei; v.expErr = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with inputs released.
  task automatic applyStimulus(input vec_t v, output int reqCycles, output int busyCycles,
                               output logic [7:0] addrSeen, output logic addrHeld);
    reqCycles = 0;
    busyCycles = 0;
    addrSeen = '0;
    addrHeld = 1'b1;
    case (v.op)
      OP_FETCH: begin
        I_rd = 1'b1; PC_inc = v.inc; IR_ld = v.irld;
        #1;
        if (fetch_busy) busyCycles++;
        @(posedge clk); @(negedge clk);
        I_rd = 1'b0; PC_inc = 1'b0; IR_ld = 1'b0;
        addrSeen = imem_addr;
        for (int c = 0; c < 40; c++) begin
          if (!imem_req) break;
          reqCycles++;
          if (fetch_busy) busyCycles++;
          if (imem_addr !== addrSeen) addrHeld = 1'b0;
          imem_ack = (c == v.k);
          imem_rdata = (c == v.k) ? v.data : 16'($urandom);
          @(posedge clk); @(negedge clk);
          imem_ack = 1'b0;
        end
      end
      OP_JUMP: begin
        PC_ld = 1'b1;
        @(posedge clk); @(negedge clk);
        PC_ld = 1'b0;
      end
      default: begin
        PC_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        PC_clr = 1'b0;
      end
    endcase
  endtask

  task automatic runVec(input string tag, input int idx, input vec_t v);
    int reqCycles, busyCycles;
    logic [7:0] addrSeen;
    logic addrHeld;
    applyStimulus(v, reqCycles, busyCycles, addrSeen, addrHeld);
    if (v.op == OP_FETCH) begin
      checkOutput({tag, "_addr"}, idx, 32'(addrSeen), 32'(v.expAddr));
      checkOutput({tag, "_reqCycles"}, idx, reqCycles, v.expReq);
      checkOutput({tag, "_addrHeld"}, idx, 32'(addrHeld), 32'd1);
      checkOutput({tag, "_busyCycles"}, idx, busyCycles, v.expReq + 1);
    end
    checkOutput({tag, "_pc"}, idx, 32'(pc), 32'(v.expPc));
    checkOutput({tag, "_ir"}, idx, 32'(instruction), 32'(v.expIr));
    checkOutput({tag, "_err"}, idx, 32'(fetch_err), 32'(v.expErr));
    checkOutput({tag, "_busyIdle"}, idx, 32'(fetch_busy), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  vec_t table_v[14];
  int   mPc;
  int   mErr;
  logic [15:0] mIr;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Directed table: each expectation follows from the previous row's state.
    table_v[0]  = mk(OP_FETCH, 1, 1, 0,  16'h3A05, 8'h00, 1,  8'h01, 16'h3A05, 0);
    table_v[1]  = mk(OP_FETCH, 1, 1, 3,  16'h2123, 8'h01, 4,  8'h02, 16'h2123, 0);
    table_v[2]  = mk(OP_FETCH, 0, 1, 2,  16'h000F, 8'h02, 3,  8'h02, 16'h000F, 0);
    table_v[3]  = mk(OP_JUMP,  0, 0, 0,  16'h0000, 8'h00, 0,  8'h10, 16'h000F, 0);
    table_v[4]  = mk(OP_FETCH, 0, 1, 0,  16'h50FD, 8'h10, 1,  8'h10, 16'h50FD, 0);
    table_v[5]  = mk(OP_JUMP,  0, 0, 0,  16'h0000, 8'h00, 0,  8'h0C, 16'h50FD, 0);
    table_v[6]  = mk(OP_FETCH, 0, 1, 1,  16'h00F7, 8'h0C, 2,  8'h0C, 16'h00F7, 0);
    table_v[7]  = mk(OP_JUMP,  0, 0, 0,  16'h0000, 8'h00, 0,  8'h02, 16'h00F7, 0);
    table_v[8]  = mk(OP_FETCH, 0, 1, 0,  16'h127F, 8'h02, 1,  8'h02, 16'h127F, 0);
    table_v[9]  = mk(OP_JUMP,  0, 0, 0,  16'h0000, 8'h00, 0,  8'h80, 16'h127F, 0);
    table_v[10] = mk(OP_FETCH, 1, 1, 99, 16'hABCD, 8'h80, TO, 8'h80, 16'hF000, 1);
    table_v[11] = mk(OP_CLR,   0, 0, 0,  16'h0000, 8'h00, 0,  8'h00, 16'hF000, 0);
    table_v[12] = mk(OP_FETCH, 1, 0, 2,  16'h1111, 8'h00, 3,  8'h01, 16'hF000, 0);
    table_v[13] = mk(OP_FETCH, 0, 0, 0,  16'h2222, 8'h01, 1,  8'h01, 16'hF000, 0);

    #2;
    checkOutput("rst_pc", 0, 32'(pc), 32'h0);
    checkOutput("rst_ir", 0, 32'(instruction), 32'h0);
    checkOutput("rst_req", 0, 32'(imem_req), 32'h0);
    checkOutput("rst_addr", 0, 32'(imem_addr), 32'h0);
    checkOutput("rst_busy", 0, 32'(fetch_busy), 32'h0);
    checkOutput("rst_err", 0, 32'(fetch_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) runVec("tbl", i, table_v[i]);

    // Ack while no request is outstanding must be ignored.
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("strayAck_ir", 0, 32'(instruction), 32'hF000);
    checkOutput("strayAck_pc", 0, 32'(pc), 32'h01);
    checkOutput("strayAck_req", 0, 32'(imem_req), 32'h0);

    // PC_clr in the second WAIT cycle collides with an ack.
    I_rd = 1'b1; PC_inc = 1'b1; IR_ld = 1'b1;
    @(posedge clk); @(negedge clk);
    I_rd = 1'b0; PC_inc = 1'b0; IR_ld = 1'b0;
    checkOutput("clrAbort_req1", 0, 32'(imem_req), 32'h1);
    @(posedge clk); @(negedge clk);
    PC_clr = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(posedge clk); @(negedge clk);
    PC_clr = 1'b0; imem_ack = 1'b0;
    checkOutput("clrAbort_req", 0, 32'(imem_req), 32'h0);
    checkOutput("clrAbort_pc", 0, 32'(pc), 32'h0);
    checkOutput("clrAbort_ir", 0, 32'(instruction), 32'hF000);
    checkOutput("clrAbort_busy", 0, 32'(fetch_busy), 32'h0);
    @(posedge clk); @(negedge clk);
    checkOutput("clrAbort_reqStay", 0, 32'(imem_req), 32'h0);

    // PC_ld with I_rd: jump to 0+0-1=FF, fetch from old PC 00; PC_ld held in WAIT is ignored and
    // the increment wraps FF to 00.
    I_rd = 1'b1; PC_ld = 1'b1; PC_inc = 1'b1; IR_ld = 1'b1;
    @(posedge clk); @(negedge clk);
    I_rd = 1'b0; PC_inc = 1'b0; IR_ld = 1'b0;
    checkOutput("ldRd_addr", 0, 32'(imem_addr), 32'h00);
    checkOutput("ldRd_pc", 0, 32'(pc), 32'hFF);
    imem_ack = 1'b1; imem_rdata = 16'h0005;
    @(posedge clk); @(negedge clk);
    imem_ack = 1'b0; PC_ld = 1'b0;
    checkOutput("wrap_pc", 0, 32'(pc), 32'h00);
    checkOutput("wrap_ir", 0, 32'(instruction), 32'h0005);

    // Asynchronous reset in the middle of a fetch.
    runVec("preRst", 0, mk(OP_JUMP, 0, 0, 0, 16'h0, 8'h0, 0, 8'h04, 16'h0005, 0));
    I_rd = 1'b1; PC_inc = 1'b1; IR_ld = 1'b1;
    @(posedge clk); @(negedge clk);
    I_rd = 1'b0; PC_inc = 1'b0; IR_ld = 1'b0;
    checkOutput("midRst_reqBefore", 0, 32'(imem_req), 32'h1);
    checkOutput("midRst_addrBefore", 0, 32'(imem_addr), 32'h04);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRst_req", 0, 32'(imem_req), 32'h0);
    checkOutput("midRst_pc", 0, 32'(pc), 32'h0);
    checkOutput("midRst_ir", 0, 32'(instruction), 32'h0);
    checkOutput("midRst_addr", 0, 32'(imem_addr), 32'h0);
    checkOutput("midRst_busy", 0, 32'(fetch_busy), 32'h0);
    checkOutput("midRst_err", 0, 32'(fetch_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized run against the reference model.
    doReset();
    mPc = 0; mErr = 0; mIr = 16'h0000;
    for (int n = 0; n < 80; n++) begin
      vec_t v;
      int r, off;
      r = $urandom_range(0, 9);
      v = mk(OP_FETCH, 1'($urandom), 1'($urandom), $urandom_range(0, 4), 16'($urandom),
             8'h0, 0, 8'h0, 16'h0, 0);
      if (r >= 6 && r <= 8) v.op = OP_JUMP;
      else if (r == 9) v.op = OP_CLR;
      if ($urandom_range(0, 7) == 0) v.k = 30;
      if (v.op == OP_FETCH) begin
        v.expAddr = 8'(mPc);
        if (v.k < TO) begin
          v.expReq = v.k + 1;
          if (v.irld) mIr = v.data;
          if (v.inc) mPc = (mPc + 1) % 256;
        end else begin
          v.expReq = TO;
          mIr = 16'hF000;
          mErr = 1;
        end
      end else if (v.op == OP_JUMP) begin
        off = int'(mIr[7:0]);
        if (off >= 128) off -= 256;
        mPc = (((mPc + off - 1) % 256) + 256) % 256;
      end else begin
        mPc = 0;
        mErr = 0;
      end
      v.expPc = 8'(mPc);
      v.expIr = mIr;
      v.expErr = 1'(mErr);
      runVec("rnd", n, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
